pipe_chain: RTL and testbench
=============================

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, payload width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 5, number of pipeline stages (2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream item offered.
REQ-006 SHALL have port in_ready  output  1  stage 0 accepts this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  item presented downstream.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port hold  input  1  freeze all stages.
REQ-012 SHALL have port flush_mask  input  DEPTH  per-stage kill; bit 0 = input stage.
REQ-013 SHALL have port occupancy  output  4  number of valid entries held.
REQ-014 SHALL have port drop_cnt  output  16  saturating count of flushed items.

Function
REQ-015 SHALL hold per stage i a data register and a valid bit; stage DEPTH-1 feeds the output.
REQ-016 SHALL compute effective valid v[i] = valid[i] AND NOT flush_mask[i]; all handshake logic uses v[i].
REQ-017 SHALL compute ready chain rdy[DEPTH] = out_ready, rdy[i] = NOT v[i] OR rdy[i+1], so bubbles collapse.
REQ-018 SHALL drive in_ready = rdy[0] AND NOT hold; out_valid = v[DEPTH-1] AND NOT hold; out_data = data of stage DEPTH-1.
REQ-019 SHALL, when hold=0, load stage i from stage i-1 (stage 0 from input) whenever rdy[i]=1; the loaded valid is the source's effective valid.
REQ-020 SHALL, when hold=1, keep all data and valid bits except that flush_mask still clears valid bits.
REQ-021 SHALL never transfer a flushed item; a flushed item vacates its stage at the next edge, and a stage receives no new item from a flushed predecessor.
REQ-022 SHALL give latency DEPTH cycles from input handshake to out_valid on an empty pipe with out_ready=1, throughput one item per cycle.
REQ-023 SHALL drive occupancy = popcount of stored valid bits (skid included when present), combinational from registers.
REQ-024 SHALL add popcount(valid AND flush_mask) to drop_cnt each edge, saturating at 0xFFFF, with no wrap.
REQ-025 SHALL ignore in_data when in_valid=0; the data register content of invalid stages is don't-care.

Reset
REQ-026 SHALL, while rst_n=0, clear all valid bits, skid valid, and drop_cnt immediately; data registers reset to 0.
REQ-027 SHALL produce out_valid=0, occupancy=0, drop_cnt=0, in_ready=1 (hold=0) during and after reset.
REQ-028 SHALL discard in-flight items on reset mid-operation; no partial transfer completes.

Configuration
REQ-029 SHALL, with macro PIPE_CHAIN_SKID_EN defined, insert a one-entry skid register after stage DEPTH-1 with rdy[DEPTH] = NOT skid_valid.
REQ-030 SHALL, with PIPE_CHAIN_SKID_EN, present the skid entry first when valid; otherwise bypass stage DEPTH-1 directly (latency unchanged); the last-stage item moves into skid when presented and out_ready=0.
REQ-031 SHALL, with PIPE_CHAIN_SKID_EN, leave the skid unaffected by flush_mask, freeze it under hold, and remove any combinational path from out_ready to in_ready.
REQ-032 SHALL, without PIPE_CHAIN_SKID_EN, contain no skid register, with out_ready combinationally gating in_ready.

Verification
REQ-033 Stream: DEPTH=5, push 0x1..0xA back-to-back, out_ready=1 -> out 0x1 at cycle 5, then one per cycle in order, occupancy steady at 5.
REQ-034 Backpressure: fill with 0x11..0x15, out_ready=0 -> in_ready=0 when occupancy=5 (6 with skid); release -> 0x11..0x15 exit in order, none lost.
REQ-035 Bubble collapse: items only in stages 0 and 4, out_ready=0 -> stage 0 item advances to stage 3 after 3 edges; in_ready stays 1 until full.
REQ-036 Flush: full pipe, flush_mask=5'b01010 for one cycle -> occupancy drops to 3, drop_cnt=2, surviving items exit in order.
REQ-037 Hold and reset: hold=1 for 4 cycles -> out_valid=0, in_ready=0, occupancy unchanged; rst_n low mid-stream -> occupancy=0, drop_cnt=0 asynchronously.
REQ-038 Saturation: force 0xFFFE, flush 2 valid stages -> drop_cnt=0xFFFF and remains there on further flushes.

Source files
------------

// File: rtl/pipe_chain.sv
// pipe_chain: elastic valid/ready pipeline with bubble collapse, hold and per-stage flush.
// Define PIPE_CHAIN_SKID_EN to add a one-entry output skid register.
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic [DEPTH-1:0] flush_mask,
  output logic [3:0]       occupancy,
  output logic [15:0]      drop_cnt
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] src_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH:0]   rdy;
  logic             tail_rdy;
  logic [3:0]       held_n;
  logic [3:0]       kill_n;
  logic [15:0]      drop_q;
  logic [16:0]      drop_sum;

  assign v        = valid_q & ~flush_mask;
  assign in_ready = rdy[0] & ~hold;
  assign drop_cnt = drop_q;
  assign drop_sum = {1'b0, drop_q} + {13'd0, kill_n};

  // ready ripples back from the tail; an empty stage is always ready
  always_comb begin
    logic r;
    rdy = '0;
    r = tail_rdy;
    rdy[DEPTH] = r;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r = ~v[i] | r;
      rdy[i] = r;
    end
  end

  // each stage's source: the input for stage 0, the previous stage otherwise
  always_comb begin
    src_v = {v[DEPTH-2:0], in_valid};
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_d[i] = data_q[i-1];
    end
  end

  // stored and flushed entry counts
  always_comb begin
    held_n = '0;
    kill_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      held_n = held_n + 4'(valid_q[i]);
      kill_n = kill_n + 4'(valid_q[i] & flush_mask[i]);
    end
  end

  // stage registers: advance when ready, otherwise keep the surviving item
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!hold && rdy[i]) begin
          valid_q[i] <= src_v[i];
          if (src_v[i]) begin
            data_q[i] <= src_d[i];
          end
        end else begin
          valid_q[i] <= v[i];
        end
      end
    end
  end

  // saturating count of killed items
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop_sum[16]) begin
      drop_q <= 16'hFFFF;
    end else begin
      drop_q <= drop_sum[15:0];
    end
  end

`ifdef PIPE_CHAIN_SKID_EN
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;

  assign tail_rdy  = ~skid_v;
  assign out_valid = (skid_v | v[DEPTH-1]) & ~hold;
  assign out_data  = skid_v ? skid_d : data_q[DEPTH-1];
  assign occupancy = held_n + 4'(skid_v);

  // skid catches an undelivered tail item and drains when downstream accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v <= 1'b0;
      skid_d <= '0;
    end else if (!hold) begin
      if (skid_v) begin
        if (out_ready) begin
          skid_v <= 1'b0;
        end
      end else if (v[DEPTH-1] && !out_ready) begin
        skid_v <= 1'b1;
        skid_d <= data_q[DEPTH-1];
      end
    end
  end
`else
  assign tail_rdy  = out_ready;
  assign out_valid = v[DEPTH-1] & ~hold;
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = held_n;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed and random stimulus against a slot-level model.
// Honours PIPE_CHAIN_SKID_EN the same way the design does.
module tb_pipe_chain;
  localparam int W = 32;
  localparam int D = 5;
`ifdef PIPE_CHAIN_SKID_EN
  localparam int CAP = D + 1;
`else
  localparam int CAP = D;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         hold = 1'b0;
  logic [D-1:0] flush_mask = '0;
  logic [3:0]   occupancy;
  logic [15:0]  drop_cnt;

  int n_assert = 0;
  int n_fail = 0;

  // model: which positions hold an item and its value, plus the skid entry
  bit           m_v [D];
  logic [W-1:0] m_d [D];
  bit           m_sv;
  logic [W-1:0] m_sd;
  int           m_drop;
  logic [W-1:0] seen [$];

  pipe_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold(hold), .flush_mask(flush_mask),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_v[i] = 1'b0;
    m_sv = 1'b0;
    m_drop = 0;
  endtask

  // outputs implied by the current model state and inputs
  task automatic check_now();
    bit           e [D];
    int           nfree;
    int           occ;
    bit           ov;
    bit           ir;
    logic [W-1:0] od;
    nfree = 0;
    occ = int'(m_sv);
    for (int i = 0; i < D; i++) begin
      e[i] = m_v[i] && !flush_mask[i];
      occ += int'(m_v[i]);
      if (!e[i]) nfree++;
    end
`ifdef PIPE_CHAIN_SKID_EN
    ov = m_sv || e[D-1];
    od = m_sv ? m_sd : m_d[D-1];
    ir = (nfree > 0) || !m_sv;
`else
    ov = e[D-1];
    od = m_d[D-1];
    ir = (nfree > 0) || out_ready;
`endif
    ov = ov && !hold;
    ir = ir && !hold;
    chk("in_ready", 64'(in_ready), 64'(ir));
    chk("out_valid", 64'(out_valid), 64'(ov));
    if (ov) chk("out_data", 64'(out_data), 64'(od));
    chk("occupancy", 64'(occupancy), 64'(occ));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  // one clock of the model: kill flagged items, deliver, shift, accept
  task automatic model_step();
    int k;
    k = 0;
    for (int i = 0; i < D; i++) begin
      if (m_v[i] && flush_mask[i]) begin
        m_v[i] = 1'b0;
        k++;
      end
    end
    m_drop = (m_drop + k > 65535) ? 65535 : m_drop + k;
    if (!hold) begin
`ifdef PIPE_CHAIN_SKID_EN
      if (m_sv) begin
        if (out_ready) m_sv = 1'b0;
      end else if (m_v[D-1]) begin
        if (!out_ready) begin
          m_sv = 1'b1;
          m_sd = m_d[D-1];
        end
        m_v[D-1] = 1'b0;
      end
`else
      if (m_v[D-1] && out_ready) m_v[D-1] = 1'b0;
`endif
      for (int i = D - 2; i >= 0; i--) begin
        if (m_v[i] && !m_v[i+1]) begin
          m_v[i+1] = 1'b1;
          m_d[i+1] = m_d[i];
          m_v[i] = 1'b0;
        end
      end
      if (in_valid && !m_v[0]) begin
        m_v[0] = 1'b1;
        m_d[0] = in_data;
      end
    end
  endtask

  // called at a falling edge with inputs set; returns at the next one
  task automatic cyc();
    #1;
    check_now();
    if (out_valid && out_ready) seen.push_back(out_data);
    if (rst_n) model_step();
    else model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < CAP + 3; i++) begin
      in_data = $urandom;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // reset state
    cyc();
    cyc();
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // stream 1..10 back to back
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = (k < 10);
      in_data = W'(k + 1);
      #1;
      chk("stream_v", 64'(out_valid), 64'(k >= 5 && k < 15));
      if (k >= 5 && k < 15) chk("stream_d", 64'(out_data), 64'(k - 4));
      if (k >= 5 && k <= 10) chk("stream_occ", 64'(occupancy), 64'd5);
      cyc();
    end

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h11;
    for (int k = 0; k < CAP + 3; k++) begin
      if (in_ready) begin
        cyc();
        in_data = in_data + 1;
      end else begin
        cyc();
      end
    end
    in_valid = 1'b0;
    #1;
    chk("bp_full_occ", 64'(occupancy), 64'(CAP));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    seen.delete();
    out_ready = 1'b1;
    for (int k = 0; k < CAP + 3; k++) cyc();
    chk("bp_count", 64'(seen.size()), 64'(CAP));
    for (int i = 0; i < seen.size(); i++) begin
      chk("bp_order", 64'(seen[i]), 64'(32'h11 + i));
    end

    // bubble collapse: items at stage 0 and stage 4 only
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA0;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    in_valid = 1'b1;
    in_data = 32'hB0;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    #1;
`ifdef PIPE_CHAIN_SKID_EN
    chk("bubble_stages", 64'(dut.valid_q), 64'(5'b01000));
`else
    chk("bubble_stages", 64'(dut.valid_q), 64'(5'b11000));
`endif
    chk("bubble_in_ready", 64'(in_ready), 64'd1);
    fill();

    // flush stages 1 and 3 of a full pipe
    #1;
    chk("flush_pre_occ", 64'(occupancy), 64'(CAP));
    flush_mask = 5'b01010;
    cyc();
    flush_mask = '0;
    #1;
    chk("flush_occ", 64'(occupancy), 64'(CAP - 2));
    chk("flush_drop", 64'(drop_cnt), 64'd2);
    seen.delete();
    out_ready = 1'b1;
    for (int k = 0; k < CAP + 3; k++) cyc();
    chk("flush_count", 64'(seen.size()), 64'(CAP - 2));

    // hold for four cycles with three items inside
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      cyc();
    end
    hold = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_out_valid", 64'(out_valid), 64'd0);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_occ", 64'(occupancy), 64'd3);
      cyc();
    end
    hold = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < CAP + 2; k++) cyc();

    // random traffic
    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      hold = ($urandom_range(0, 9) == 0);
      flush_mask = ($urandom_range(0, 7) == 0) ? D'($urandom) : '0;
      cyc();
    end
    hold = 1'b0;
    flush_mask = '0;

    // asynchronous reset in the middle of traffic
    fill();
    in_valid = 1'b1;
    out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // drop counter saturation
    fill();
    force dut.drop_q = 16'hFFFE;
    #1;
    chk("sat_forced", 64'(drop_cnt), 64'hFFFE);
    release dut.drop_q;
    m_drop = 65534;
    flush_mask = 5'b00011;
    cyc();
    flush_mask = '0;
    #1;
    chk("sat_ffff", 64'(drop_cnt), 64'hFFFF);
    fill();
    flush_mask = 5'b11111;
    cyc();
    flush_mask = '0;
    #1;
    chk("sat_stay", 64'(drop_cnt), 64'hFFFF);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
